// File: rtl/afifo_push_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NumReq requesters.
// Grants one requester per burst of up to BurstLen words; stalls (never rotates) on full.
module afifo_push_arbiter #(
  parameter  int DataSize = 8,
  parameter  int NumReq   = 4,
  parameter  int BurstLen = 4,
  localparam int GW       = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CW       = (BurstLen > 1) ? $clog2(BurstLen + 1) : 1
) (
  input  logic                         Wclk,
  input  logic                         Wresetn,
  input  logic [NumReq-1:0]            Req,
  input  logic [NumReq*DataSize-1:0]   ReqData,
  output logic [NumReq-1:0]            Ack,
  input  logic                         full,
  output logic                         Push,
  output logic [DataSize-1:0]          DataIn,
  output logic [GW-1:0]                GrantId,
  output logic                         Busy
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GW-1:0]       r_grant_id;
  logic [GW-1:0]       w_grant_nxt;
  logic [GW-1:0]       r_last_grant;
  logic [GW-1:0]       w_last_nxt;
  logic [CW-1:0]       r_burst_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_found;
  logic [GW-1:0]       w_owner;
  logic                w_push;
  logic [DataSize-1:0] w_req_words [NumReq];

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      w_req_words[i] = ReqData[i*DataSize +: DataSize];
    end
  end

  // Round-robin scan starting just after the last owner, wrapping modulo NumReq.
  always_comb begin
    logic [GW-1:0] idx;
    w_found = 1'b0;
    w_owner = r_last_grant;
    idx     = '0;
    for (int k = 1; k <= NumReq; k++) begin
      idx = GW'((int'(r_last_grant) + k) % NumReq);
      if (!w_found && Req[idx]) begin
        w_found = 1'b1;
        w_owner = idx;
      end
    end
  end

  // A word presented while reset is asserted is suppressed so its Ack never fires
  // and the requester keeps holding it.
  assign w_push  = (r_state == OWN) && Wresetn && Req[r_grant_id] && !full;
  assign Push    = w_push;
  assign DataIn  = w_push ? w_req_words[r_grant_id] : '0;
  assign GrantId = r_grant_id;
  assign Busy    = (r_state == OWN);

  always_comb begin
    Ack             = '0;
    Ack[r_grant_id] = w_push;
  end

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_owner;
          w_cnt_nxt   = '0;
          w_state_nxt = OWN;
        end
      end
      OWN: begin
        if (!Req[r_grant_id]) begin
          w_last_nxt  = r_grant_id;
          w_state_nxt = IDLE;
        end else if (w_push) begin
          if (r_burst_cnt == CW'(BurstLen - 1)) begin
            w_last_nxt  = r_grant_id;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_burst_cnt + CW'(1);
          end
        end
        // full with Req held: everything holds, the grant does not rotate.
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge Wclk) begin
    if (!Wresetn) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NumReq - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_afifo_push_arbiter.sv
// Self-checking bench for afifo_push_arbiter: requester models feed words,
// a scoreboard holds the expected (owner, word) push order.
module tb_afifo_push_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BL = 4;
  localparam int GW = 2;

  logic             Wclk = 1'b0;
  logic             Wresetn;
  logic [NR-1:0]    Req;
  logic [NR*DW-1:0] ReqData;
  logic [NR-1:0]    Ack;
  logic             full;
  logic             Push;
  logic [DW-1:0]    DataIn;
  logic [GW-1:0]    GrantId;
  logic             Busy;

  always #5 Wclk = ~Wclk;

  afifo_push_arbiter #(.DataSize(DW), .NumReq(NR), .BurstLen(BL)) dut (
    .Wclk    (Wclk),
    .Wresetn (Wresetn),
    .Req     (Req),
    .ReqData (ReqData),
    .Ack     (Ack),
    .full    (full),
    .Push    (Push),
    .DataIn  (DataIn),
    .GrantId (GrantId),
    .Busy    (Busy)
  );

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] src_data [NR][32];
  int            src_len [NR];
  int            src_pos [NR];
  int            ack_cnt [NR];
  int            n_checks = 0;
  int            n_errors = 0;

  logic          s_push;
  logic [NR-1:0] s_ack;
  logic [GW-1:0] s_gid;
  logic          s_busy;
  logic [DW-1:0] s_data;

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NR; i++) if (src_pos[i] < src_len[i]) p = 1'b1;
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      Req[i] = (src_pos[i] < src_len[i]);
      if (Req[i]) ReqData[i*DW +: DW] = src_data[i][src_pos[i]];
      else        ReqData[i*DW +: DW] = '0;
    end
  endtask

  task automatic load(input int id, input int base, input int n);
    for (int k = 0; k < n; k++) src_data[id][k] = DW'(base + k);
    src_len[id] = n;
    src_pos[id] = 0;
  endtask

  task automatic expect_words(input int id, input int base, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = id;
      e.data = DW'(base + k);
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample and score outputs at negedge, then advance requesters on Ack.
  task automatic cycle();
    exp_t          e;
    logic [NR-1:0] exp_ack;
    @(negedge Wclk);
    s_push = Push;
    s_ack  = Ack;
    s_gid  = GrantId;
    s_busy = Busy;
    s_data = DataIn;
    exp_ack = s_push ? (NR'(1) << s_gid) : '0;
    n_checks++;
    if (s_ack !== exp_ack) begin
      n_errors++;
      $display("FAIL ack_onehot: got %b expected %b", s_ack, exp_ack);
    end
    n_checks++;
    if (s_push === 1'b1 && full === 1'b1) begin
      n_errors++;
      $display("FAIL push_while_full: got Push=1 expected Push=0");
    end
    if (s_push === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_push: got id=%0d data=%0h expected no push", s_gid, s_data);
      end else begin
        e = exp_q.pop_front();
        if (s_gid !== GW'(e.id) || s_data !== e.data) begin
          n_errors++;
          $display("FAIL push_order: got id=%0d data=%0h expected id=%0d data=%0h",
                   s_gid, s_data, e.id, e.data);
        end
      end
    end else begin
      n_checks++;
      if (s_data !== '0) begin
        n_errors++;
        $display("FAIL datain_no_push: got %0h expected 0", s_data);
      end
    end
    @(posedge Wclk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (s_ack[i] === 1'b1) begin
        src_pos[i]++;
        ack_cnt[i]++;
      end
    end
    drive();
  endtask

  task automatic run_drain(input int bound, input string name);
    int c = 0;
    while ((exp_q.size() > 0 || pending()) && c < bound) begin
      cycle();
      c++;
    end
    n_checks++;
    if (exp_q.size() != 0 || pending()) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d words outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      ack_cnt[i] = 0;
    end
  endtask

  task automatic do_reset();
    clear_sources();
    exp_q.delete();
    full = 1'b0;
    drive();
    Wresetn = 1'b0;
    cycle();
    cycle();
    Wresetn = 1'b1;
  endtask

  task automatic test_reset();
    Wresetn = 1'b0;
    full    = 1'b0;
    clear_sources();
    for (int i = 0; i < NR; i++) load(i, 8'hA0 + i, 4);
    drive();
    @(posedge Wclk);
    #1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      n_checks++;
      if (s_push !== 1'b0 || s_ack !== '0 || s_busy !== 1'b0 || s_data !== '0 || s_gid !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs: got push=%b ack=%b busy=%b data=%0h gid=%0d expected all 0",
                 s_push, s_ack, s_busy, s_data, s_gid);
      end
    end
    clear_sources();
    drive();
    Wresetn = 1'b1;
    cycle();
    n_checks++;
    if (s_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", s_busy);
    end
  endtask

  task automatic test_single();
    load(2, 10, 8);
    expect_words(2, 10, 8);
    drive();
    for (int c = 0; c < 10; c++) begin
      logic exp_p;
      exp_p = (c % 5) != 0;
      cycle();
      n_checks++;
      if (s_push !== exp_p || s_busy !== exp_p) begin
        n_errors++;
        $display("FAIL single_pattern c%0d: got push=%b busy=%b expected %b", c, s_push, s_busy, exp_p);
      end
      if (exp_p) begin
        n_checks++;
        if (s_gid !== GW'(2)) begin
          n_errors++;
          $display("FAIL single_gid c%0d: got %0d expected 2", c, s_gid);
        end
      end
    end
    run_drain(5, "single");
  endtask

  task automatic test_all_req();
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 8'h40 + i*16, 8);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) expect_words(i, 8'h40 + i*16 + r*4, 4);
    drive();
    for (int c = 0; c < 40; c++) begin
      logic exp_p;
      exp_p = (c % 5) != 0;
      cycle();
      n_checks++;
      if (s_push !== exp_p || s_busy !== exp_p) begin
        n_errors++;
        $display("FAIL rotate_pattern c%0d: got push=%b busy=%b expected %b", c, s_push, s_busy, exp_p);
      end
    end
    run_drain(4, "rotate");
    for (int i = 0; i < NR; i++) begin
      n_checks++;
      if (ack_cnt[i] !== 8) begin
        n_errors++;
        $display("FAIL rotate_acks r%0d: got %0d expected 8", i, ack_cnt[i]);
      end
    end
  endtask

  task automatic test_full_stall();
    logic exp_p [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    load(1, 8'h80, 8);
    expect_words(1, 8'h80, 8);
    drive();
    for (int c = 0; c < 3; c++) cycle();
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_checks++;
      if (s_push !== 1'b0 || s_busy !== 1'b1 || s_gid !== GW'(1)) begin
        n_errors++;
        $display("FAIL full_stall c%0d: got push=%b busy=%b gid=%0d expected 0 1 1", c, s_push, s_busy, s_gid);
      end
    end
    full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_checks++;
      if (s_push !== exp_p[c] || s_busy !== exp_p[c]) begin
        n_errors++;
        $display("FAIL full_resume c%0d: got push=%b busy=%b expected %b", c, s_push, s_busy, exp_p[c]);
      end
    end
    run_drain(10, "full");
  endtask

  task automatic test_early_release();
    logic exp_p [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_b [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    load(2, 8'h20, 1);
    expect_words(2, 8'h20, 1);
    drive();
    run_drain(10, "early_setup");
    cycle();
    cycle();
    load(3, 8'h33, 1);
    load(0, 8'h50, 4);
    expect_words(3, 8'h33, 1);
    expect_words(0, 8'h50, 4);
    drive();
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_checks++;
      if (s_push !== exp_p[c] || s_busy !== exp_b[c]) begin
        n_errors++;
        $display("FAIL early_pattern c%0d: got push=%b busy=%b expected %b %b",
                 c, s_push, s_busy, exp_p[c], exp_b[c]);
      end
    end
    n_checks++;
    if (s_gid !== GW'(0)) begin
      n_errors++;
      $display("FAIL early_wrap_gid: got %0d expected 0", s_gid);
    end
    run_drain(10, "early");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    load(1, 8'h11, 1);
    expect_words(1, 8'h11, 1);
    drive();
    run_drain(10, "midrst_setup");
    cycle();
    cycle();
    load(2, 8'h60, 8);
    expect_words(2, 8'h60, 2);
    drive();
    for (int c = 0; c < 3; c++) cycle();
    Wresetn = 1'b0;
    load(0, 8'h70, 4);
    drive();
    cycle();
    n_checks++;
    if (s_push !== 1'b0 || s_ack !== '0) begin
      n_errors++;
      $display("FAIL midrst_assert: got push=%b ack=%b expected 0 0", s_push, s_ack);
    end
    Wresetn = 1'b1;
    cycle();
    n_checks++;
    if (s_push !== 1'b0 || s_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_idle: got push=%b busy=%b expected 0 0", s_push, s_busy);
    end
    expect_words(0, 8'h70, 4);
    expect_words(2, 8'h62, 6);
    run_drain(30, "midrst");
  endtask

  initial begin
    Req     = '0;
    ReqData = '0;
    test_reset();
    test_single();
    test_all_req();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
